// File: rtl/a3_hazard_ctrl_if.sv
// D-stage operand/write descriptors in, stall and forwarding selects out.
// The master side supplies the D-stage descriptors; the slave side is the hazard unit.
interface a3_hazard_ctrl_if;
    logic [4:0] a1_d;
    logic [4:0] a2_d;
    logic [1:0] tuse_rs_d;
    logic [1:0] tuse_rt_d;
    logic [4:0] a3_d;
    logic [1:0] tnew_d;
    logic       stall;
    logic [1:0] fwd_rs_d;
    logic [1:0] fwd_rt_d;
    logic [1:0] fwd_rs_e;
    logic [1:0] fwd_rt_e;
    logic       fwd_rt_m;
    logic [4:0] a3_w;

    modport master (
        output a1_d, a2_d, tuse_rs_d, tuse_rt_d, a3_d, tnew_d,
        input  stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m, a3_w
    );

    modport slave (
        input  a1_d, a2_d, tuse_rs_d, tuse_rt_d, a3_d, tnew_d,
        output stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m, a3_w
    );
endinterface

// File: rtl/a3_hazard_ctrl.sv
// Tracks A3/Tnew through E, M and W for a five-stage MIPS pipe and derives
// the stall signal plus all forwarding selects from the consumers' A1/A2/Tuse.
module a3_hazard_ctrl (
    input  logic              clk,
    input  logic              reset,
    a3_hazard_ctrl_if.slave   hz
);

    logic [4:0] r_a1_e;
    logic [4:0] r_a2_e;
    logic [4:0] r_a3_e;
    logic [1:0] r_tnew_e;
    logic [4:0] r_a2_m;
    logic [4:0] r_a3_m;
    logic [1:0] r_tnew_m;
    logic [4:0] r_a3_w;

    logic       w_stall;

    // Register 0 is hardwired, so it never produces a match.
    function automatic logic f_match(input logic [4:0] x, input logic [4:0] a3);
        return (x != 5'd0) && (x == a3);
    endfunction

    function automatic logic f_hazard(input logic [4:0] x, input logic [1:0] tuse,
                                      input logic [4:0] a3_e, input logic [1:0] tnew_e,
                                      input logic [4:0] a3_m, input logic [1:0] tnew_m);
        return (tuse != 2'd3) &&
               ((f_match(x, a3_e) && (tnew_e > tuse)) ||
                (f_match(x, a3_m) && (tnew_m > tuse)));
    endfunction

    // The youngest matching stage owns the register; if its result is not ready yet the
    // select stays 0 and the stall logic holds the consumer.
    function automatic logic [1:0] f_fwd_d(input logic [4:0] x,
                                           input logic [4:0] a3_e, input logic [1:0] tnew_e,
                                           input logic [4:0] a3_m, input logic [1:0] tnew_m,
                                           input logic [4:0] a3_w);
        if (f_match(x, a3_e)) begin
            return (tnew_e == 2'd0) ? 2'd3 : 2'd0;
        end else if (f_match(x, a3_m)) begin
            return (tnew_m == 2'd0) ? 2'd2 : 2'd0;
        end else if (f_match(x, a3_w)) begin
            return 2'd1;
        end
        return 2'd0;
    endfunction

    function automatic logic [1:0] f_fwd_e(input logic [4:0] x,
                                           input logic [4:0] a3_m, input logic [1:0] tnew_m,
                                           input logic [4:0] a3_w);
        if (f_match(x, a3_m)) begin
            return (tnew_m == 2'd0) ? 2'd2 : 2'd0;
        end else if (f_match(x, a3_w)) begin
            return 2'd1;
        end
        return 2'd0;
    endfunction

    assign w_stall = f_hazard(hz.a1_d, hz.tuse_rs_d, r_a3_e, r_tnew_e, r_a3_m, r_tnew_m) ||
                     f_hazard(hz.a2_d, hz.tuse_rt_d, r_a3_e, r_tnew_e, r_a3_m, r_tnew_m);

    assign hz.stall    = w_stall;
    assign hz.fwd_rs_d = f_fwd_d(hz.a1_d, r_a3_e, r_tnew_e, r_a3_m, r_tnew_m, r_a3_w);
    assign hz.fwd_rt_d = f_fwd_d(hz.a2_d, r_a3_e, r_tnew_e, r_a3_m, r_tnew_m, r_a3_w);
    assign hz.fwd_rs_e = f_fwd_e(r_a1_e, r_a3_m, r_tnew_m, r_a3_w);
    assign hz.fwd_rt_e = f_fwd_e(r_a2_e, r_a3_m, r_tnew_m, r_a3_w);
    assign hz.fwd_rt_m = f_match(r_a2_m, r_a3_w);
    assign hz.a3_w     = r_a3_w;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_a1_e   <= 5'd0;
            r_a2_e   <= 5'd0;
            r_a3_e   <= 5'd0;
            r_tnew_e <= 2'd0;
            r_a2_m   <= 5'd0;
            r_a3_m   <= 5'd0;
            r_tnew_m <= 2'd0;
            r_a3_w   <= 5'd0;
        end else begin
            if (w_stall) begin
                r_a1_e   <= 5'd0;
                r_a2_e   <= 5'd0;
                r_a3_e   <= 5'd0;
                r_tnew_e <= 2'd0;
            end else begin
                r_a1_e   <= hz.a1_d;
                r_a2_e   <= hz.a2_d;
                r_a3_e   <= hz.a3_d;
                r_tnew_e <= hz.tnew_d;
            end
            // M and W drain every cycle; a stall only affects what enters E.
            r_a2_m   <= r_a2_e;
            r_a3_m   <= r_a3_e;
            r_tnew_m <= (r_tnew_e == 2'd0) ? 2'd0 : r_tnew_e - 2'd1;
            r_a3_w   <= r_a3_m;
        end
    end

endmodule

// File: tb/tb_a3_hazard_ctrl.sv
// Self-checking bench for a3_hazard_ctrl: expectations are queued with a due cycle
// as stimulus is driven and compared when that cycle's outputs are sampled.
module tb_a3_hazard_ctrl;

    localparam int SigStall = 0;
    localparam int SigRsD   = 1;
    localparam int SigRtD   = 2;
    localparam int SigRsE   = 3;
    localparam int SigRtE   = 4;
    localparam int SigRtM   = 5;
    localparam int SigA3W   = 6;

    typedef struct {
        int    cyc;
        string tag;
        int    sig;
        int    val;
    } exp_t;

    logic clk;
    logic reset;
    a3_hazard_ctrl_if hz_if ();

    exp_t sb[$];
    int   cur_cyc;
    int   n_checks;
    int   n_pass;

    a3_hazard_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: run still active at %0t, required finish earlier", $time);
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s (cycle %0d): got %0d, expected %0d", tag, cur_cyc, obs, exp);
        end
    endtask

    function automatic int get_sig(input int s);
        case (s)
            SigStall: return int'(hz_if.stall);
            SigRsD:   return int'(hz_if.fwd_rs_d);
            SigRtD:   return int'(hz_if.fwd_rt_d);
            SigRsE:   return int'(hz_if.fwd_rs_e);
            SigRtE:   return int'(hz_if.fwd_rt_e);
            SigRtM:   return int'(hz_if.fwd_rt_m);
            default:  return int'(hz_if.a3_w);
        endcase
    endfunction

    task automatic expect_at(input int dly, input string tag, input int sig, input int val);
        exp_t e;
        e.cyc = cur_cyc + dly;
        e.tag = tag;
        e.sig = sig;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic drive(input logic [4:0] a1, input logic [4:0] a2, input logic [1:0] tu_rs,
                         input logic [1:0] tu_rt, input logic [4:0] a3, input logic [1:0] tn);
        hz_if.a1_d      = a1;
        hz_if.a2_d      = a2;
        hz_if.tuse_rs_d = tu_rs;
        hz_if.tuse_rt_d = tu_rt;
        hz_if.a3_d      = a3;
        hz_if.tnew_d    = tn;
    endtask

    task automatic idle();
        drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0);
    endtask

    // Sample on the falling edge, then advance one clock.
    task automatic tick();
        exp_t keep[$];
        @(negedge clk);
        keep = {};
        foreach (sb[i]) begin
            if (sb[i].cyc == cur_cyc) begin
                check_eq(sb[i].tag, get_sig(sb[i].sig), sb[i].val);
            end else begin
                keep.push_back(sb[i]);
            end
        end
        sb = keep;
        @(posedge clk);
        #1;
        cur_cyc++;
    endtask

    task automatic flush();
        idle();
        repeat (3) tick();
    endtask

    initial begin
        logic [4:0] ra3;
        cur_cyc  = 0;
        n_checks = 0;
        n_pass   = 0;

        // Reset with random D inputs
        reset = 1'b0;
        drive(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)),
              2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), 2'($urandom_range(0, 2)));
        tick();
        drive(5'($urandom_range(1, 31)), 5'($urandom_range(1, 31)), 2'd0, 2'd0,
              5'($urandom_range(1, 31)), 2'd2);
        expect_at(0, "rst_stall", SigStall, 0);
        expect_at(0, "rst_rs_d", SigRsD, 0);
        expect_at(0, "rst_rt_d", SigRtD, 0);
        expect_at(0, "rst_rs_e", SigRsE, 0);
        expect_at(0, "rst_rt_e", SigRtE, 0);
        expect_at(0, "rst_rt_m", SigRtM, 0);
        expect_at(0, "rst_a3w", SigA3W, 0);
        tick();
        reset = 1'b1;
        drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd5, 2'd1);
        expect_at(3, "first_a3w", SigA3W, 5);
        tick();
        flush();

        // Hazard-free random stream: a3_d shows up on a3_w three cycles later
        for (int i = 0; i < 16; i++) begin
            ra3 = 5'($urandom_range(0, 31));
            drive(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 2'd3, 2'd3, ra3,
                  2'($urandom_range(0, 2)));
            expect_at(0, "pipe_stall", SigStall, 0);
            expect_at(3, "pipe_a3w", SigA3W, int'(ra3));
            tick();
        end
        flush();

        // Load-use: one stall, then W forward in E
        drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd8, 2'd2);
        tick();
        drive(5'd8, 5'd0, 2'd1, 2'd3, 5'd9, 2'd1);
        expect_at(0, "lu_stall1", SigStall, 1);
        tick();
        expect_at(0, "lu_stall2", SigStall, 0);
        expect_at(0, "lu_rs_d", SigRsD, 0);
        tick();
        idle();
        expect_at(0, "lu_rs_e", SigRsE, 1);
        expect_at(0, "lu_a3w", SigA3W, 8);
        tick();
        flush();

        // Branch after ALU: one stall then M forward
        drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd9, 2'd1);
        tick();
        drive(5'd9, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0);
        expect_at(0, "ba_stall1", SigStall, 1);
        tick();
        expect_at(0, "ba_stall2", SigStall, 0);
        expect_at(0, "ba_rs_d", SigRsD, 2);
        tick();
        flush();

        // Branch after load: two stalls then W forward
        drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd10, 2'd2);
        tick();
        drive(5'd10, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0);
        expect_at(0, "bl_stall1", SigStall, 1);
        tick();
        expect_at(0, "bl_stall2", SigStall, 1);
        tick();
        expect_at(0, "bl_stall3", SigStall, 0);
        expect_at(0, "bl_rs_d", SigRsD, 1);
        tick();
        flush();

        // jal result forwarded from E in D, then from M in E
        drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd31, 2'd0);
        tick();
        drive(5'd0, 5'd31, 2'd3, 2'd0, 5'd0, 2'd0);
        expect_at(0, "jal_stall", SigStall, 0);
        expect_at(0, "jal_rt_d", SigRtD, 3);
        tick();
        idle();
        expect_at(0, "jal_rt_e", SigRtE, 2);
        tick();
        flush();

        // Register zero never stalls or forwards
        drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd2);
        tick();
        drive(5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0);
        expect_at(0, "r0_stall", SigStall, 0);
        expect_at(0, "r0_rs_d", SigRsD, 0);
        expect_at(0, "r0_rt_d", SigRtD, 0);
        tick();
        idle();
        expect_at(0, "r0_rs_e", SigRsE, 0);
        tick();
        flush();

        // Priority: three $4 writers, reader in E takes M (youngest)
        repeat (3) begin
            drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd4, 2'd1);
            tick();
        end
        drive(5'd4, 5'd0, 2'd1, 2'd3, 5'd0, 2'd0);
        expect_at(0, "pr_stall", SigStall, 0);
        expect_at(0, "pr_rs_d", SigRsD, 0);
        tick();
        idle();
        expect_at(0, "pr_rs_e", SigRsE, 2);
        tick();
        flush();

        // Priority in D: E, M and W all hold ready $4 results; E wins
        repeat (2) begin
            drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd4, 2'd1);
            tick();
        end
        drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd4, 2'd0);
        tick();
        drive(5'd0, 5'd4, 2'd3, 2'd0, 5'd0, 2'd0);
        expect_at(0, "pd_stall", SigStall, 0);
        expect_at(0, "pd_rt_d", SigRtD, 3);
        tick();
        idle();
        expect_at(0, "pd_rt_e", SigRtE, 2);
        tick();
        flush();

        // Store data forwarded from W in M
        drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd4, 2'd1);
        tick();
        drive(5'd0, 5'd4, 2'd3, 2'd2, 5'd0, 2'd0);
        expect_at(0, "sw_stall", SigStall, 0);
        tick();
        idle();
        expect_at(0, "sw_rt_e", SigRtE, 2);
        tick();
        expect_at(0, "sw_rt_m", SigRtM, 1);
        tick();
        flush();

        // Reset asserted in the stall cycle drops the pending hazard
        drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd8, 2'd2);
        tick();
        drive(5'd8, 5'd0, 2'd1, 2'd3, 5'd9, 2'd1);
        reset = 1'b0;
        expect_at(0, "rs_stall1", SigStall, 1);
        tick();
        reset = 1'b1;
        expect_at(0, "rs_stall2", SigStall, 0);
        expect_at(0, "rs_rs_d", SigRsD, 0);
        expect_at(0, "rs_a3w0", SigA3W, 0);
        tick();
        idle();
        expect_at(0, "rs_rs_e", SigRsE, 0);
        expect_at(0, "rs_a3w1", SigA3W, 0);
        expect_at(1, "rs_a3w2", SigA3W, 0);
        expect_at(2, "rs_a3w3", SigA3W, 9);
        repeat (3) tick();
        flush();

        check_eq("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/a3_hazard_ctrl.md
# a3_hazard_ctrl

Consumer-side counterpart of the D-stage write-register (A3) selector in the five-stage MIPS pipeline. Each instruction's A3 and result-ready time (Tnew) are carried through E, M and W. Later readers' source registers (A1/A2) and need-by times (Tuse) are compared against them to produce the stall signal and all forwarding mux selects. The block also drives the GRF write address from the W stage.

## Interface
- No parameters; register index width fixed at 5, time fields at 2 bits.
- `clk` in 1: pipeline clock, all state on rising edge.
- `reset` in 1: synchronous, active-low; clears all stage state.
- `a1_d` in 5: rs index of the instruction in D.
- `a2_d` in 5: rt index of the instruction in D.
- `tuse_rs_d` in 2: cycles until D instruction needs rs (0, 1, 2); 3 = rs unused.
- `tuse_rt_d` in 2: same for rt.
- `a3_d` in 5: write register from the A3 selector (0 = no write).
- `tnew_d` in 2: cycles after entering E until result exists (0 jal, 1 ALU, 2 load).
- `stall` out 1: freeze PC and F/D register; inject bubble into D/E.
- `fwd_rs_d`, `fwd_rt_d` out 2 each: D-stage compare operand select. 0 = GRF, 1 = W, 2 = M, 3 = E.
- `fwd_rs_e`, `fwd_rt_e` out 2 each: E-stage ALU operand select. 0 = pipe reg, 1 = W, 2 = M.
- `fwd_rt_m` out 1: M-stage store data select. 0 = pipe reg, 1 = W.
- `a3_w` out 5: GRF write address; GRF write enable is `a3_w != 0`.

## Operation
- State: per-stage registers `a1_e`, `a2_e`, `a3_e`, `tnew_e`; `a2_m`, `a3_m`, `tnew_m`; `a3_w`.
- Advance when `stall` = 0: E regs load the D inputs.
- Advance when `stall` = 1: E regs load a bubble (all fields 0).
- Every cycle, regardless of `stall`:
  - M loads `a2_e`, `a3_e`, and `tnew_m <= (tnew_e == 0) ? 0 : tnew_e - 1`.
  - W loads `a3_m`.
- Match rule: address X matches stage S when X != 0 and X == a3_S. Register 0 never matches, stalls or forwards.
- Stall (combinational), evaluated per operand r in {rs, rt} with Tuse != 3:
  - Stall if the operand matches E and `tnew_e > tuse`.
  - Stall if the operand matches M and `tnew_m > tuse`.
  - `stall` is the OR over both operands.
- D forward priority: E match with `tnew_e == 0` -> 3; else M match with `tnew_m == 0` -> 2; else W match -> 1; else 0.
  - The youngest match blocks older ones: an E match with Tnew > 0 yields 0, and stall covers it when needed.
- E forward (on `a1_e`/`a2_e`): M match with `tnew_m == 0` -> 2; else W match -> 1; else 0.
- M forward (on `a2_m`): W match -> 1; else 0.
- Forward selects are never gated by `stall`. Downstream ignores D selects while stalled.

## Timing
- Reset: when `reset` = 0 at a rising edge, every stage register becomes 0. Outputs then read `stall` = 0, all `fwd_*` = 0, `a3_w` = 0.
- Reset asserted mid-stall: bubbles everywhere on the next cycle. Pending hazards are dropped and `stall` drops the cycle after the reset edge.
- All outputs are combinational from current state and D inputs; zero-cycle latency.
- State update latency is 1 cycle per stage: a3_d is visible as `a3_w` 3 cycles after it is sampled without stall.
- Load-use (Tnew 2, Tuse 1) gives exactly 1 stall cycle.
- Load followed by a Tuse-0 consumer gives 2 stall cycles.
- ALU result followed by a Tuse-0 consumer gives 1 stall cycle.
- Simultaneous matches in E, M and W: the youngest stage wins, per the priority above.
- Back-to-back stalls keep the E bubble; M/W keep draining.

## Test plan
- Reset: hold `reset` = 0 for 2 cycles with random D inputs. Required: `stall` = 0, all fwd = 0, `a3_w` = 0. Then the first real instruction with `a3_d` = 5 appears on `a3_w` 3 cycles later.
- Load-use: lw $8 (`a3_d` = 8, `tnew_d` = 2), then add using rs = 8 (`tuse_rs_d` = 1). Required:
  - `stall` = 1 for 1 cycle, then 0 with `fwd_rs_d` = 0.
  - Next cycle `fwd_rs_e` = 1 (W).
- Branch after ALU: add $9 (`tnew_d` = 1), then beq rs = 9 (Tuse 0). Required: 1 stall cycle, then `fwd_rs_d` = 2; branch after lw gives 2 stall cycles, then `fwd_rs_d` = 1.
- Register zero: writer `a3_d` = 0, `tnew_d` = 2, then reader rs = 0, Tuse 0. Required: `stall` = 0, all fwd = 0.
- Priority: writes to $4 in three consecutive ALU instructions, then a reader of $4 in E (Tuse 1). Required: `fwd_rs_e` = 2 (M, youngest), not 1. With sw rt = 4 in M and a $4 writer in W: `fwd_rt_m` = 1.
- Reset during stall: lw $8 + use, assert `reset` = 0 in the stall cycle. Required: the next cycle has `stall` = 0 and all stage state 0.
